dispatch_ctrl: RTL and testbench

Dispatch-width controller between the 3-wide fetch/decode output and the dispatch stage. Each cycle it decides how many fetched instructions may dispatch in program order. The decision accounts for RS, ROB and free-list capacity, an in-flight branch limit, halt, and the post-squash recovery window. It drives the per-slot enable that gates the dispatch `valid` bits and the fetch stall. It also keeps the in-flight branch count and a dispatch-stall performance counter.

---
 rtl/dispatch_ctrl_pkg.sv | 14 +
 rtl/dispatch_slot_scan.sv | 61 ++++++
 rtl/sys_defs.svh | 8 +
 rtl/dispatch_ctrl.sv | 118 +++++++++++
 tb/tb_dispatch_ctrl.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/dispatch_ctrl_pkg.sv
// Shared types and constants for the dispatch-width controller.
`include "sys_defs.svh"

package dispatch_ctrl_pkg;

    localparam int unsigned SLOTS = 3;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        RECOVER = 2'd1,
        HALTED  = 2'd2
    } DISPATCH_CTRL_STATE;

endpackage

// File: rtl/dispatch_slot_scan.sv
// Combinational in-order grant of the three fetch slots against RS/ROB/PR capacity,
// the in-flight branch limit and the halt cut.
module dispatch_slot_scan
    import dispatch_ctrl_pkg::*;
#(
    parameter int unsigned MAX_BR = 4,
    parameter int unsigned BR_W   = 3
) (
    input  logic             enable_i,
    input  logic [SLOTS-1:0] if_valid_i,
    input  logic [SLOTS-1:0] is_branch_i,
    input  logic [SLOTS-1:0] is_halt_i,
    input  logic [SLOTS-1:0] needs_pr_i,
    input  logic [1:0]       rs_free_i,
    input  logic [1:0]       rob_free_i,
    input  logic [1:0]       pr_free_i,
    input  logic [BR_W-1:0]  br_inflight_i,
    output logic [SLOTS-1:0] grant_o,
    output logic [1:0]       br_grant_o,
    output logic             halt_grant_o
);

    logic       scan_go;
    logic       slot_ok;
    logic [2:0] used;
    logic [2:0] pr_used;
    logic [1:0] br_used;

    always_comb begin
        scan_go      = enable_i;
        slot_ok      = 1'b0;
        used         = '0;
        pr_used      = '0;
        br_used      = '0;
        grant_o      = '0;
        halt_grant_o = 1'b0;
        // Slot 2 is oldest; the first refusal ends the scan so grants stay contiguous.
        for (int i = 2; i >= 0; i--) begin
            slot_ok = scan_go && if_valid_i[i]
                && (used < {1'b0, rs_free_i})
                && (used < {1'b0, rob_free_i})
                && ((pr_used + {2'b00, needs_pr_i[i]}) <= {1'b0, pr_free_i})
                && (!is_branch_i[i]
                    || ((32'(br_inflight_i) + 32'(br_used)) < MAX_BR));
            if (slot_ok) begin
                grant_o[i] = 1'b1;
                used       = used + 3'd1;
                pr_used    = pr_used + {2'b00, needs_pr_i[i]};
                br_used    = br_used + {1'b0, is_branch_i[i]};
                if (is_halt_i[i]) begin
                    scan_go      = 1'b0;
                    halt_grant_o = 1'b1;
                end
            end else begin
                scan_go = 1'b0;
            end
        end
        br_grant_o = br_used;
    end

endmodule

// File: rtl/sys_defs.svh
// System-wide defaults for the dispatch controller.
`ifndef SYS_DEFS_SVH
`define SYS_DEFS_SVH

`define MAX_BR         4
`define RECOVER_CYCLES 2

`endif

// File: rtl/dispatch_ctrl.sv
// Dispatch-width controller: run/recover/halt FSM, in-flight branch count and
// dispatch-stall counter around the ordered slot scan.
`include "sys_defs.svh"

module dispatch_ctrl
    import dispatch_ctrl_pkg::*;
#(
    parameter int unsigned MAX_BR         = `MAX_BR,
    parameter int unsigned RECOVER_CYCLES = `RECOVER_CYCLES,
    localparam int unsigned BR_W          = $clog2(MAX_BR + 1),
    localparam int unsigned REC_W         = ($clog2(RECOVER_CYCLES + 1) > 0)
                                            ? $clog2(RECOVER_CYCLES + 1) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [SLOTS-1:0] if_valid,
    input  logic [SLOTS-1:0] is_branch,
    input  logic [SLOTS-1:0] is_halt,
    input  logic [SLOTS-1:0] needs_pr,
    input  logic [1:0]       rs_free_cnt,
    input  logic [1:0]       rob_free_cnt,
    input  logic [1:0]       pr_free_cnt,
    input  logic             br_resolve,
    input  logic             squash,
    output logic [SLOTS-1:0] dis_en,
    output logic [1:0]       dis_num,
    output logic             fetch_stall,
    output logic [BR_W-1:0]  br_inflight,
    output logic             halted,
    output logic [31:0]      stall_cycles
);

    DISPATCH_CTRL_STATE state_q, state_d;
    logic [REC_W-1:0]   rec_cnt_q, rec_cnt_d;
    logic [BR_W-1:0]    br_inflight_q, br_inflight_d;
    logic [BR_W-1:0]    br_sum;
    logic [31:0]        stall_q, stall_d;

    logic               scan_en;
    logic [SLOTS-1:0]   grant;
    logic [1:0]         br_grant;
    logic               halt_grant;

    // Reset is folded in so the grant is held low for the whole reset window.
    assign scan_en = reset && (state_q == RUN) && !squash;

    dispatch_slot_scan #(
        .MAX_BR (MAX_BR),
        .BR_W   (BR_W)
    ) u_scan (
        .enable_i      (scan_en),
        .if_valid_i    (if_valid),
        .is_branch_i   (is_branch),
        .is_halt_i     (is_halt),
        .needs_pr_i    (needs_pr),
        .rs_free_i     (rs_free_cnt),
        .rob_free_i    (rob_free_cnt),
        .pr_free_i     (pr_free_cnt),
        .br_inflight_i (br_inflight_q),
        .grant_o       (grant),
        .br_grant_o    (br_grant),
        .halt_grant_o  (halt_grant)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= RUN;
            rec_cnt_q     <= '0;
            br_inflight_q <= '0;
            stall_q       <= '0;
        end else begin
            state_q       <= state_d;
            rec_cnt_q     <= rec_cnt_d;
            br_inflight_q <= br_inflight_d;
            stall_q       <= stall_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rec_cnt_d = rec_cnt_q;
        if (squash) begin
            state_d   = RECOVER;
            rec_cnt_d = REC_W'(RECOVER_CYCLES - 1);
        end else begin
            unique case (state_q)
                RUN: begin
                    if (halt_grant) state_d = HALTED;
                end
                RECOVER: begin
                    if (rec_cnt_q == '0) state_d = RUN;
                    else                 rec_cnt_d = rec_cnt_q - REC_W'(1);
                end
                HALTED:  state_d = HALTED;
                default: state_d = RUN;
            endcase
        end

        // A resolve with nothing in flight is dropped rather than underflowing.
        br_sum = br_inflight_q + BR_W'(br_grant);
        if (squash)                                     br_inflight_d = '0;
        else if (br_resolve && (br_inflight_q != '0))   br_inflight_d = br_sum - BR_W'(1);
        else                                            br_inflight_d = br_sum;

        stall_d = stall_q;
        if ((state_q != HALTED) && if_valid[2] && !grant[2]) stall_d = stall_q + 32'd1;
    end

    always_comb begin
        dis_en       = grant;
        dis_num      = {1'b0, grant[2]} + {1'b0, grant[1]} + {1'b0, grant[0]};
        fetch_stall  = reset && ((if_valid & ~grant) != '0);
        br_inflight  = br_inflight_q;
        halted       = (state_q == HALTED);
        stall_cycles = stall_q;
    end

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Scoreboard bench for dispatch_ctrl: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares.
module tb_dispatch_ctrl;

    logic        clock;
    logic        reset;
    logic [2:0]  if_valid, is_branch, is_halt, needs_pr;
    logic [1:0]  rs_free_cnt, rob_free_cnt, pr_free_cnt;
    logic        br_resolve, squash;
    logic [2:0]  dis_en;
    logic [1:0]  dis_num;
    logic        fetch_stall;
    logic [2:0]  br_inflight;
    logic        halted;
    logic [31:0] stall_cycles;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic [2:0]  en;
        logic [1:0]  num;
        logic        fs;
        logic [2:0]  br;
        logic        hlt;
        logic [31:0] stall;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];

    dispatch_ctrl dut (
        .clock        (clock),
        .reset        (reset),
        .if_valid     (if_valid),
        .is_branch    (is_branch),
        .is_halt      (is_halt),
        .needs_pr     (needs_pr),
        .rs_free_cnt  (rs_free_cnt),
        .rob_free_cnt (rob_free_cnt),
        .pr_free_cnt  (pr_free_cnt),
        .br_resolve   (br_resolve),
        .squash       (squash),
        .dis_en       (dis_en),
        .dis_num      (dis_num),
        .fetch_stall  (fetch_stall),
        .br_inflight  (br_inflight),
        .halted       (halted),
        .stall_cycles (stall_cycles)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic void chk(input string name, input int c, input logic [31:0] act,
                                input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, c, act, exp);
        end
    endfunction

    always @(negedge clock) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk("dis_en",       e.cyc, 32'(dis_en),       32'(e.en));
            chk("dis_num",      e.cyc, 32'(dis_num),      32'(e.num));
            chk("fetch_stall",  e.cyc, 32'(fetch_stall),  32'(e.fs));
            chk("br_inflight",  e.cyc, 32'(br_inflight),  32'(e.br));
            chk("halted",       e.cyc, 32'(halted),       32'(e.hlt));
            chk("stall_cycles", e.cyc, stall_cycles,      e.stall);
        end
    end

    task automatic set_in(input logic [2:0] iv, input logic [2:0] br, input logic [2:0] hlt,
                          input logic [2:0] npr, input logic [1:0] rs, input logic [1:0] rob,
                          input logic [1:0] pr, input logic res, input logic sq);
        if_valid     = iv;
        is_branch    = br;
        is_halt      = hlt;
        needs_pr     = npr;
        rs_free_cnt  = rs;
        rob_free_cnt = rob;
        pr_free_cnt  = pr;
        br_resolve   = res;
        squash       = sq;
    endtask

    // Expectation for the current cycle, then advance to just after the next edge.
    task automatic step(input logic [2:0] en, input logic [1:0] num, input logic fs,
                        input logic [2:0] br, input logic hlt, input logic [31:0] stall);
        exp_t e;
        cyc++;
        e.en = en; e.num = num; e.fs = fs; e.br = br; e.hlt = hlt; e.stall = stall;
        e.cyc = cyc;
        sb_q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        set_in(3'b111, 3'b000, 3'b000, 3'b000, 2'd3, 2'd3, 2'd3, 1'b0, 1'b0);
        #2;
        chk("rst_dis_en",      0, 32'(dis_en),      32'd0);
        chk("rst_dis_num",     0, 32'(dis_num),     32'd0);
        chk("rst_fetch_stall", 0, 32'(fetch_stall), 32'd0);
        chk("rst_br_inflight", 0, 32'(br_inflight), 32'd0);
        chk("rst_halted",      0, 32'(halted),      32'd0);
        chk("rst_stall",       0, stall_cycles,     32'd0);
        #10 reset = 1'b1;
        @(posedge clock);
        #1;

        // Capacity limits
        step(3'b111, 2'd3, 1'b1 ^ 1'b1, 3'd0, 1'b0, 32'd0);
        set_in(3'b111, 3'b000, 3'b000, 3'b000, 2'd3, 2'd1, 2'd3, 1'b0, 1'b0);
        step(3'b100, 2'd1, 1'b1, 3'd0, 1'b0, 32'd0);
        set_in(3'b111, 3'b000, 3'b000, 3'b000, 2'd3, 2'd0, 2'd3, 1'b0, 1'b0);
        step(3'b000, 2'd0, 1'b1, 3'd0, 1'b0, 32'd0);
        step(3'b000, 2'd0, 1'b1, 3'd0, 1'b0, 32'd1);
        set_in(3'b111, 3'b000, 3'b000, 3'b111, 2'd3, 2'd3, 2'd1, 1'b0, 1'b0);
        step(3'b100, 2'd1, 1'b1, 3'd0, 1'b0, 32'd2);
        set_in(3'b111, 3'b000, 3'b000, 3'b111, 2'd2, 2'd3, 2'd3, 1'b0, 1'b0);
        step(3'b110, 2'd2, 1'b1, 3'd0, 1'b0, 32'd2);
        set_in(3'b101, 3'b000, 3'b000, 3'b000, 2'd3, 2'd3, 2'd3, 1'b0, 1'b0);
        step(3'b100, 2'd1, 1'b1, 3'd0, 1'b0, 32'd2);

        // Branch limit and resolve without bypass
        set_in(3'b111, 3'b001, 3'b000, 3'b000, 2'd3, 2'd3, 2'd3, 1'b0, 1'b0);
        step(3'b111, 2'd3, 1'b0, 3'd0, 1'b0, 32'd2);
        set_in(3'b111, 3'b011, 3'b000, 3'b000, 2'd3, 2'd3, 2'd3, 1'b0, 1'b0);
        step(3'b111, 2'd3, 1'b0, 3'd1, 1'b0, 32'd2);
        set_in(3'b111, 3'b111, 3'b000, 3'b000, 2'd3, 2'd3, 2'd3, 1'b0, 1'b0);
        step(3'b100, 2'd1, 1'b1, 3'd3, 1'b0, 32'd2);
        set_in(3'b111, 3'b100, 3'b000, 3'b000, 2'd3, 2'd3, 2'd3, 1'b1, 1'b0);
        step(3'b000, 2'd0, 1'b1, 3'd4, 1'b0, 32'd2);
        set_in(3'b111, 3'b100, 3'b000, 3'b000, 2'd3, 2'd3, 2'd3, 1'b0, 1'b0);
        step(3'b111, 2'd3, 1'b0, 3'd3, 1'b0, 32'd3);
        set_in(3'b111, 3'b000, 3'b000, 3'b000, 2'd3, 2'd3, 2'd3, 1'b1, 1'b0);
        step(3'b111, 2'd3, 1'b0, 3'd4, 1'b0, 32'd3);

        // Halt cut and halted hold
        set_in(3'b111, 3'b000, 3'b010, 3'b000, 2'd3, 2'd3, 2'd3, 1'b0, 1'b0);
        step(3'b110, 2'd2, 1'b1, 3'd3, 1'b0, 32'd3);
        set_in(3'b111, 3'b000, 3'b000, 3'b000, 2'd3, 2'd3, 2'd3, 1'b0, 1'b0);
        step(3'b000, 2'd0, 1'b1, 3'd3, 1'b1, 32'd3);
        step(3'b000, 2'd0, 1'b1, 3'd3, 1'b1, 32'd3);

        // Squash out of HALTED, then recovery window
        set_in(3'b111, 3'b000, 3'b000, 3'b000, 2'd3, 2'd3, 2'd3, 1'b0, 1'b1);
        step(3'b000, 2'd0, 1'b1, 3'd3, 1'b1, 32'd3);
        set_in(3'b111, 3'b000, 3'b000, 3'b000, 2'd3, 2'd3, 2'd3, 1'b0, 1'b0);
        step(3'b000, 2'd0, 1'b1, 3'd0, 1'b0, 32'd3);
        step(3'b000, 2'd0, 1'b1, 3'd0, 1'b0, 32'd4);
        step(3'b111, 2'd3, 1'b0, 3'd0, 1'b0, 32'd5);

        // Back-to-back squash reloads the window
        set_in(3'b111, 3'b000, 3'b000, 3'b000, 2'd3, 2'd3, 2'd3, 1'b0, 1'b1);
        step(3'b000, 2'd0, 1'b1, 3'd0, 1'b0, 32'd5);
        step(3'b000, 2'd0, 1'b1, 3'd0, 1'b0, 32'd6);
        set_in(3'b111, 3'b000, 3'b000, 3'b000, 2'd3, 2'd3, 2'd3, 1'b0, 1'b0);
        step(3'b000, 2'd0, 1'b1, 3'd0, 1'b0, 32'd7);
        step(3'b000, 2'd0, 1'b1, 3'd0, 1'b0, 32'd8);
        step(3'b111, 2'd3, 1'b0, 3'd0, 1'b0, 32'd9);

        // Async reset in the middle of RECOVER
        set_in(3'b111, 3'b000, 3'b000, 3'b000, 2'd3, 2'd3, 2'd3, 1'b0, 1'b1);
        step(3'b000, 2'd0, 1'b1, 3'd0, 1'b0, 32'd9);
        set_in(3'b111, 3'b000, 3'b000, 3'b000, 2'd3, 2'd3, 2'd3, 1'b0, 1'b0);
        chk("pre_rst_stall", cyc + 1, stall_cycles, 32'd10);
        #1 reset = 1'b0;
        #1;
        chk("arst_dis_en",      cyc + 1, 32'(dis_en),        32'd0);
        chk("arst_dis_num",     cyc + 1, 32'(dis_num),       32'd0);
        chk("arst_fetch_stall", cyc + 1, 32'(fetch_stall),   32'd0);
        chk("arst_br_inflight", cyc + 1, 32'(br_inflight),   32'd0);
        chk("arst_halted",      cyc + 1, 32'(halted),        32'd0);
        chk("arst_stall",       cyc + 1, stall_cycles,       32'd0);
        chk("arst_state",       cyc + 1, 32'(dut.state_q),   32'd0);
        @(posedge clock);
        #2 reset = 1'b1;
        @(posedge clock);
        #1;
        cyc = cyc + 2;
        step(3'b111, 2'd3, 1'b0, 3'd0, 1'b0, 32'd0);
        set_in(3'b111, 3'b000, 3'b000, 3'b000, 2'd3, 2'd0, 2'd3, 1'b0, 1'b0);
        step(3'b000, 2'd0, 1'b1, 3'd0, 1'b0, 32'd0);

        for (int k = 0; k < 5 && sb_q.size() > 0; k++) @(negedge clock);
        #1;
        chk("scoreboard_drain", cyc, 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
